osc_sequencer: RTL and testbench

OSC_SEQUENCER -- requirements
Module: osc_sequencer

---
 rtl/osc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_osc_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_sequencer.sv
// Oscillator sequencer: shadow/active configuration registers, a start/retune/stop FSM
// and a sample-tick divider. All outputs come straight from flops.
module osc_sequencer (
  input  logic        Fg_clk,
  input  logic        Resetn,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cmd_start,
  input  logic        cmd_commit,
  input  logic        cmd_stop,
  output logic        Ready,
  output logic        Enable,
  output logic        FreqChng,
  output logic [2:0]  Mode,
  output logic [31:0] init1,
  output logic [31:0] init2,
  output logic        busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    RUN    = 2'd2,
    RETUNE = 2'd3
  } seqState_t;

  seqState_t state_q, state_d;

  logic [31:0] ampSh_q, coefSh_q;
  logic [2:0]  modeSh_q;
  logic [15:0] divSh_q, guardSh_q;

  logic [31:0] ampAct_q, coefAct_q;
  logic [2:0]  modeAct_q;
  logic [15:0] divAct_q, guardAct_q, divAct_d;

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] guardCnt_q, guardCnt_d, guardNext;

  logic ready_q, ready_d;
  logic enable_q, enable_d;
  logic freqChng_q, freqChng_d;
  logic busy_q, busy_d;

  logic loadActive;
  logic running;
  logic tick;

  // A stop in the same cycle suppresses both the copy and the transition.
  assign loadActive = !cmd_stop &&
                      ((state_q == IDLE && cmd_start) || (state_q == RUN && cmd_commit));
  assign running    = (state_q == RUN) || (state_q == RETUNE);
  assign tick       = running && (cnt_q == divAct_q);
  assign divAct_d   = loadActive ? divSh_q : divAct_q;

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    guardNext = guardCnt_q;
    if (tick && guardCnt_q != 16'hFFFF) begin
      guardNext = guardCnt_q + 16'd1;
    end
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_start) state_d = PRIME;
      PRIME:   state_d = RUN;
      RUN:     if (cmd_commit) state_d = RETUNE;
      RETUNE:  if (guardNext >= guardAct_q) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (cmd_stop) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    cnt_d      = 16'd0;
    guardCnt_d = 16'd0;
    if (running && (state_d == RUN || state_d == RETUNE)) begin
      cnt_d = (cnt_q == divAct_q) ? 16'd0 : cnt_q + 16'd1;
    end
    if (state_q == RETUNE && state_d == RETUNE) begin
      guardCnt_d = guardNext;
    end
    ready_d    = (state_d == PRIME);
    busy_d     = (state_d == PRIME) || (state_d == RETUNE);
    freqChng_d = (state_q == RUN) && (state_d == RETUNE);
    enable_d   = (state_d == RUN || state_d == RETUNE) && (cnt_d == divAct_d);
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      ampSh_q   <= 32'd0;
      coefSh_q  <= 32'd0;
      modeSh_q  <= 3'd0;
      divSh_q   <= 16'd0;
      guardSh_q <= 16'd0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0: ampSh_q  <= cfg_wdata;
        2'd1: coefSh_q <= cfg_wdata;
        2'd2: modeSh_q <= cfg_wdata[2:0];
        2'd3: begin
          divSh_q   <= cfg_wdata[15:0];
          guardSh_q <= cfg_wdata[31:16];
        end
        default: ;
      endcase
    end
  end

  // The copy reads the shadow flops, so a write in the same cycle lands only in shadow.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      ampAct_q   <= 32'd0;
      coefAct_q  <= 32'd0;
      modeAct_q  <= 3'd0;
      guardAct_q <= 16'd0;
    end else if (loadActive) begin
      ampAct_q   <= ampSh_q;
      coefAct_q  <= coefSh_q;
      modeAct_q  <= modeSh_q;
      guardAct_q <= guardSh_q;
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      divAct_q   <= 16'd0;
      cnt_q      <= 16'd0;
      guardCnt_q <= 16'd0;
      ready_q    <= 1'b0;
      enable_q   <= 1'b0;
      freqChng_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      divAct_q   <= divAct_d;
      cnt_q      <= cnt_d;
      guardCnt_q <= guardCnt_d;
      ready_q    <= ready_d;
      enable_q   <= enable_d;
      freqChng_q <= freqChng_d;
      busy_q     <= busy_d;
    end
  end

  assign Ready    = ready_q;
  assign Enable   = enable_q;
  assign FreqChng = freqChng_q;
  assign busy     = busy_q;
  assign Mode     = modeAct_q;
  assign init1    = ampAct_q;
  assign init2    = coefAct_q;
  assign state    = state_q;

endmodule

// File: tb/tb_osc_sequencer.sv
// Directed self-checking bench for osc_sequencer: start-up, retune, write/commit race,
// command priority, divider extremes and asynchronous reset during retune.
module tb_osc_sequencer;

  logic        Fg_clk = 1'b0;
  logic        Resetn;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cmd_start, cmd_commit, cmd_stop;
  logic        Ready, Enable, FreqChng, busy;
  logic [2:0]  Mode;
  logic [31:0] init1, init2;
  logic [1:0]  state;

  int vectorCount = 0;
  int missCount   = 0;

  osc_sequencer dut (
    .Fg_clk     (Fg_clk),
    .Resetn     (Resetn),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cmd_start  (cmd_start),
    .cmd_commit (cmd_commit),
    .cmd_stop   (cmd_stop),
    .Ready      (Ready),
    .Enable     (Enable),
    .FreqChng   (FreqChng),
    .Mode       (Mode),
    .init1      (init1),
    .init2      (init2),
    .busy       (busy),
    .state      (state)
  );

  always #5 Fg_clk = ~Fg_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge Fg_clk);
      #1;
    end
  endtask

  // Drives one cycle of inputs, lets the edge take them, then returns to idle inputs.
  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                               input logic start, input logic commit, input logic stop);
    cfg_we     = we;
    cfg_addr   = addr;
    cfg_wdata  = wdata;
    cmd_start  = start;
    cmd_commit = commit;
    cmd_stop   = stop;
    stepCycles(1);
    cfg_we     = 1'b0;
    cfg_addr   = 2'd0;
    cfg_wdata  = 32'd0;
    cmd_start  = 1'b0;
    cmd_commit = 1'b0;
    cmd_stop   = 1'b0;
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitState(input logic [1:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      stepCycles(1);
      n++;
    end
    checkOutput(tag, 32'(state), 32'(target));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"},    32'(state),    32'd0);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_ready"},    32'(Ready),    32'd0);
    checkOutput({tag, "_enable"},   32'(Enable),   32'd0);
    checkOutput({tag, "_freqchng"}, 32'(FreqChng), 32'd0);
    checkOutput({tag, "_mode"},     32'(Mode),     32'd0);
    checkOutput({tag, "_init1"},    init1,         32'd0);
    checkOutput({tag, "_init2"},    init2,         32'd0);
  endtask

  initial begin
    bit [6:0] expEn;
    bit [6:0] expBusy;
    int       n;
    bit       sawEnable;

    Resetn     = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = 2'd0;
    cfg_wdata  = 32'd0;
    cmd_start  = 1'b0;
    cmd_commit = 1'b0;
    cmd_stop   = 1'b0;
    #23;
    checkAllZero("reset");
    @(posedge Fg_clk);
    #1;
    Resetn = 1'b1;

    // Start-up with div = 3, guard = 2.
    cfgWrite(2'd0, 32'h0100_0000);
    cfgWrite(2'd1, 32'h3FFB_0000);
    cfgWrite(2'd2, 32'h0000_0005);
    cfgWrite(2'd3, 32'h0002_0003);
    checkOutput("idleInit2", init2, 32'd0);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("primeState", 32'(state), 32'd1);
    checkOutput("primeReady", 32'(Ready), 32'd1);
    checkOutput("primeBusy",  32'(busy),  32'd1);
    checkOutput("primeInit1", init1, 32'h0100_0000);
    checkOutput("primeInit2", init2, 32'h3FFB_0000);
    checkOutput("primeMode",  32'(Mode), 32'd5);
    checkOutput("primeEnable", 32'(Enable), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      stepCycles(1);
      checkOutput($sformatf("startEnable%0d", k), 32'(Enable), 32'((k % 4) == 0));
      if (k == 1) begin
        checkOutput("runState", 32'(state), 32'd2);
        checkOutput("runReady", 32'(Ready), 32'd0);
      end
    end

    // Retune with guard = 2.
    cfgWrite(2'd1, 32'h3F00_0000);
    checkOutput("shadowOnlyInit2", init2, 32'h3FFB_0000);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("retuneState", 32'(state), 32'd3);
    checkOutput("retuneFreqChng", 32'(FreqChng), 32'd1);
    checkOutput("retuneBusy", 32'(busy), 32'd1);
    checkOutput("retuneInit2", init2, 32'h3F00_0000);
    expEn   = 7'b0100010;
    expBusy = 7'b0111111;
    for (int i = 0; i < 7; i++) begin
      stepCycles(1);
      checkOutput($sformatf("retuneEnable%0d", i), 32'(Enable), 32'(expEn[i]));
      checkOutput($sformatf("retuneBusy%0d", i), 32'(busy), 32'(expBusy[i]));
      checkOutput($sformatf("retuneFreqChng%0d", i), 32'(FreqChng), 32'd0);
    end
    checkOutput("retuneBackToRun", 32'(state), 32'd2);

    // Write and commit in the same cycle.
    applyStimulus(1'b1, 2'd1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    checkOutput("raceState", 32'(state), 32'd3);
    checkOutput("raceInit2Old", init2, 32'h3F00_0000);
    waitState(2'd2, 40, "raceReturnRun");
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("secondCommitInit2", init2, 32'h1234_5678);
    waitState(2'd2, 40, "secondReturnRun");

    // Stop beats commit; commit in IDLE is ignored.
    cfgWrite(2'd1, 32'hAAAA_5555);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("stopState", 32'(state), 32'd0);
    checkOutput("stopFreqChng", 32'(FreqChng), 32'd0);
    checkOutput("stopBusy", 32'(busy), 32'd0);
    checkOutput("stopInit2", init2, 32'h1234_5678);
    stepCycles(5);
    checkOutput("stopEnable", 32'(Enable), 32'd0);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("idleCommitState", 32'(state), 32'd0);
    checkOutput("idleCommitInit2", init2, 32'h1234_5678);
    checkOutput("idleCommitFreqChng", 32'(FreqChng), 32'd0);

    // div = 0, guard = 0.
    cfgWrite(2'd3, 32'h0000_0000);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("div0PrimeInit2", init2, 32'hAAAA_5555);
    for (int k = 1; k <= 5; k++) begin
      stepCycles(1);
      checkOutput($sformatf("div0Enable%0d", k), 32'(Enable), 32'd1);
    end
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("guard0Retune", 32'(state), 32'd3);
    checkOutput("guard0FreqChng", 32'(FreqChng), 32'd1);
    stepCycles(1);
    checkOutput("guard0Run", 32'(state), 32'd2);
    checkOutput("guard0Enable", 32'(Enable), 32'd1);

    // div = 0xFFFF: first tick 65536 cycles after PRIME.
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cfgWrite(2'd3, 32'h0000_FFFF);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      stepCycles(1);
      n++;
    end while (Enable !== 1'b1 && n < 70000);
    checkOutput("divMaxPeriod", 32'(n), 32'd65536);
    stepCycles(1);
    checkOutput("divMaxAfterTick", 32'(Enable), 32'd0);

    // Asynchronous reset landing between edges in the first RETUNE cycle.
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cfgWrite(2'd3, 32'h0005_0003);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    waitState(2'd2, 4, "arstRun");
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("arstPreFreqChng", 32'(FreqChng), 32'd1);
    #3;
    Resetn = 1'b0;
    #1;
    checkAllZero("arst");
    @(posedge Fg_clk);
    #1;
    Resetn = 1'b1;
    sawEnable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stepCycles(1);
      if (Enable === 1'b1) sawEnable = 1'b1;
    end
    checkOutput("arstNoEnable", 32'(sawEnable), 32'd0);
    checkOutput("arstIdle", 32'(state), 32'd0);
    applyStimulus(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("arstRestart", 32'(state), 32'd1);
    checkOutput("arstRestartInit2", init2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
